// File: rtl/spi_sdc.sv
// divMMC SD-card SPI master: port 0xE7 drives card chip-select, port 0xEB exchanges one byte (mode 0, MSB first).
// Build option SDC_FAST_EN: SPI ticks on both 7 MHz phases (cen and cep), so a byte takes 4 T-states instead of 8.
module spi_sdc #(
  parameter logic [7:0] PORT_CS   = 8'hE7,
  parameter logic [7:0] PORT_DATA = 8'hEB,
  parameter logic [7:0] IDLE_TX   = 8'hFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       ce,
  input  logic       cen,
  input  logic       cep,
  input  logic       iorq,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] a,
  input  logic [7:0] d,
  output logic [7:0] q,
  output logic       cs,
  output logic       ck,
  output logic       mosi,
  input  logic       miso
);

`ifdef SDC_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic       busy;
  logic       taken;
  logic       sbit;
  logic [3:0] cnt;
  logic [7:0] sreg;
  logic [7:0] rx;

  logic       tick;
  logic       io;
  logic       hit_cs;
  logic       hit_data;
  logic       start;
  logic [7:0] tx;

  always_comb begin
    tick     = cep || (FAST && cen);
    // io qualifies a fresh bus access; taken blocks re-triggering for the rest of it
    io       = ce && !iorq && (!rd || !wr) && !taken;
    hit_cs   = io && !wr && (a == PORT_CS);
    hit_data = io && (a == PORT_DATA);
    start    = enable && hit_data && !busy;
    tx       = !wr ? d : IDLE_TX;
    q        = enable ? rx : '1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cs    <= 1'b1;
      ck    <= 1'b0;
      mosi  <= 1'b1;
      rx    <= '1;
      busy  <= 1'b0;
      cnt   <= '0;
      taken <= 1'b0;
      sreg  <= '0;
      sbit  <= 1'b0;
    end else begin
      if (ce) begin
        if (iorq)
          taken <= 1'b0;
        else if (hit_cs || hit_data)
          taken <= 1'b1;
      end

      if (!enable) begin
        cs   <= 1'b1;
        busy <= 1'b0;
        ck   <= 1'b0;
        mosi <= 1'b1;
        cnt  <= '0;
      end else begin
        if (hit_cs)
          cs <= d[0];

        // a start on the same clock as a tick swallows that tick
        if (start) begin
          sreg <= tx;
          mosi <= tx[7];
          ck   <= 1'b0;
          cnt  <= '0;
          busy <= 1'b1;
        end else if (busy && tick) begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            rx   <= {sreg[6:0], sbit};
            busy <= 1'b0;
            mosi <= 1'b1;
            ck   <= 1'b0;
          end else if (!ck) begin
            ck   <= 1'b1;
            sbit <= miso;
          end else begin
            ck   <= 1'b0;
            sreg <= {sreg[6:0], sbit};
            mosi <= sreg[6];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_sdc.sv
// Directed bench for spi_sdc: Z80 port accesses, SPI bit scoreboard and read-data scoreboard.
module tb_spi_sdc;

`ifdef SDC_FAST_EN
  localparam int PW = 2;
`else
  localparam int PW = 4;
`endif

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b1;
  logic       ce     = 1'b0;
  logic       cen    = 1'b0;
  logic       cep    = 1'b0;
  logic       iorq   = 1'b1;
  logic       rd     = 1'b1;
  logic       wr     = 1'b1;
  logic [7:0] a      = '0;
  logic [7:0] d      = '0;
  logic [7:0] q;
  logic       cs;
  logic       ck;
  logic       mosi;
  logic       miso;

  logic loop     = 1'b0;
  logic miso_tie = 1'b0;
  logic mon_en   = 1'b0;
  logic ck_q     = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int hi     = 0;
  int ph     = 0;
  int base   = 0;

  logic       exp_bits[$];
  logic [7:0] rdq[$];

  spi_sdc dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .ce     (ce),
    .cen    (cen),
    .cep    (cep),
    .iorq   (iorq),
    .rd     (rd),
    .wr     (wr),
    .a      (a),
    .d      (d),
    .q      (q),
    .cs     (cs),
    .ck     (ck),
    .mosi   (mosi),
    .miso   (miso)
  );

  always #5 clock = ~clock;

  assign miso = loop ? mosi : miso_tie;

  // 8 system clocks per CPU T-state: ce on phase 0, cep on 0/4, cen on 2/6
  initial begin
    forever begin
      @(negedge clock);
      ph  = (ph + 1) % 8;
      ce  = (ph == 0);
      cep = (ph % 4 == 0);
      cen = (ph % 4 == 2);
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
  endtask

  // SPI monitor: pops one expected mosi bit per ck rise, checks high width on each fall
  always @(negedge clock) begin
    if (ck === 1'b1 && ck_q === 1'b0) begin
      hi = 1;
      if (mon_en) begin
        pulses++;
        check("ck_expected", (exp_bits.size() != 0), 8'd1);
        if (exp_bits.size() != 0) check("mosi_bit", mosi, exp_bits.pop_front());
      end
    end else if (ck === 1'b1) begin
      hi++;
    end else if (ck_q === 1'b1 && mon_en) begin
      check("ck_width", hi, PW);
    end
    ck_q = ck;
  end

  task automatic bus(input logic is_wr, input logic [7:0] addr, input logic [7:0] data, input string tag);
    logic [7:0] e;
    do begin
      @(negedge clock);
      #1;
    end while (ph != 7);
    a    = addr;
    d    = data;
    iorq = 1'b0;
    if (is_wr) wr = 1'b0;
    else       rd = 1'b0;
    repeat (2) @(negedge clock);
    if (!is_wr) begin
      e = rdq.pop_front();
      check(tag, q, e);
    end
    @(negedge clock);
    iorq = 1'b1;
    rd   = 1'b1;
    wr   = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  task automatic in_port(input logic [7:0] exp, input string tag);
    rdq.push_back(exp);
    bus(1'b0, 8'hEB, 8'h00, tag);
  endtask

  initial begin
    repeat (4) @(negedge clock);
    check("reset_cs", cs, 8'd1);
    check("reset_ck", ck, 8'd0);
    check("reset_mosi", mosi, 8'd1);
    check("reset_q", q, 8'hFF);
    reset  = 1'b0;
    mon_en = 1'b1;

    base = pulses;
    bus(1'b1, 8'hE7, 8'hFE, "");
    check("cs_low", cs, 8'd0);
    bus(1'b1, 8'hE7, 8'h01, "");
    check("cs_high", cs, 8'd1);
    check("cs_no_ck", pulses - base, 8'd0);

    loop = 1'b1;
    base = pulses;
    push_byte(8'hA5);
    bus(1'b1, 8'hEB, 8'hA5, "");
    repeat (70) @(negedge clock);
    check("a5_pulses", pulses - base, 8'd8);
    check("a5_idle_ck", ck, 8'd0);
    check("a5_idle_mosi", mosi, 8'd1);
    check("a5_drained", exp_bits.size(), 8'd0);

    loop     = 1'b0;
    miso_tie = 1'b0;
    base     = pulses;
    push_byte(8'hFF);
    in_port(8'hA5, "in_prev_rx");
    repeat (70) @(negedge clock);
    push_byte(8'hFF);
    in_port(8'h00, "in_zero");
    repeat (70) @(negedge clock);
    check("in_pulses", pulses - base, 8'd16);

    loop = 1'b1;
    base = pulses;
    push_byte(8'h3C);
    bus(1'b1, 8'hEB, 8'h3C, "");
    bus(1'b1, 8'hE7, 8'hFE, "");
    bus(1'b1, 8'hEB, 8'hC3, "");
    check("busy_cs", cs, 8'd0);
    repeat (70) @(negedge clock);
    check("busy_pulses", pulses - base, 8'd8);
    check("busy_drained", exp_bits.size(), 8'd0);
    push_byte(8'hFF);
    in_port(8'h3C, "in_3c");
    repeat (70) @(negedge clock);

    push_byte(8'h69);
    bus(1'b1, 8'hEB, 8'h69, "");
    repeat (70) @(negedge clock);
    mon_en = 1'b0;
    bus(1'b1, 8'hEB, 8'h5A, "");
    enable = 1'b0;
    @(negedge clock);
    check("dis_ck", ck, 8'd0);
    check("dis_mosi", mosi, 8'd1);
    check("dis_cs", cs, 8'd1);
    check("dis_q", q, 8'hFF);
    exp_bits.delete();
    @(negedge clock);
    mon_en = 1'b1;
    base   = pulses;
    bus(1'b1, 8'hEB, 8'h55, "");
    repeat (70) @(negedge clock);
    check("dis_no_ck", pulses - base, 8'd0);
    check("dis_q_idle", q, 8'hFF);
    enable = 1'b1;
    @(negedge clock);
    check("held_rx", q, 8'h69);

    bus(1'b1, 8'hE7, 8'hFE, "");
    mon_en = 1'b0;
    bus(1'b1, 8'hEB, 8'h00, "");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_mid_cs", cs, 8'd1);
    check("rst_mid_ck", ck, 8'd0);
    check("rst_mid_mosi", mosi, 8'd1);
    check("rst_mid_q", q, 8'hFF);
    reset = 1'b0;
    exp_bits.delete();
    mon_en = 1'b1;
    base   = pulses;
    repeat (70) @(negedge clock);
    check("rst_no_ck", pulses - base, 8'd0);
    check("rst_no_rx", q, 8'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
